pc_gen: RTL and testbench

Parametrised fetch-address generator; successor of the single-cycle PC register. Sits at the head of the fetch stage and drives the instruction-fetch address through a req/gnt handshake. Adds optional RVC (2-byte) stepping, vectored trap entry, and a one-entry pending-redirect buffer so jumps and traps arriving mid-handshake are never lost. Also exports the last granted fetch address for `mepc` capture.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_redirect_mux.sv | 35 +++
 rtl/pc_gen.sv | 115 +++++++++++
 tb/tb_pc_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch-address generator.
package pc_gen_pkg;

    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned HOLD_FLAG_W    = 3;
    localparam int unsigned HOLD_PC        = 1;
    localparam int unsigned TRAP_CAUSE_W   = 5;
    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam logic [1:0]  MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        PC_ST_RST  = 2'd0,
        PC_ST_RUN  = 2'd1,
        PC_ST_HOLD = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Redirect priority and target calculation: trap beats jump, trap vectoring,
// jump-target alignment masking. Purely combinational.
module pc_redirect_mux
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W,
    parameter bit          RVC_EN = 1'b1
) (
    input  logic                    i_trap_flag,
    input  logic                    i_trap_irq,
    input  logic [TRAP_CAUSE_W-1:0] i_trap_cause,
    input  logic [ADDR_W-1:0]       i_mtvec,
    input  logic                    i_jump_flag,
    input  logic [ADDR_W-1:0]       i_jump_addr,
    output logic                    o_redir_v,
    output logic [ADDR_W-1:0]       o_redir_addr
);

    logic [ADDR_W-1:0] w_trap_base;
    logic [ADDR_W-1:0] w_vec_off;
    logic [ADDR_W-1:0] w_trap_addr;
    logic [ADDR_W-1:0] w_jump_mask;
    logic              w_vectored;

    assign w_trap_base = {i_mtvec[ADDR_W-1:2], 2'b00};
    assign w_vec_off   = ADDR_W'({i_trap_cause, 2'b00});
    assign w_vectored  = (i_mtvec[1:0] == MTVEC_VECTORED);
    // Only interrupts are vectored; exceptions always land on the base.
    assign w_trap_addr = (w_vectored && i_trap_irq) ? w_trap_base + w_vec_off : w_trap_base;
    assign w_jump_mask = RVC_EN ? ~ADDR_W'(1) : ~ADDR_W'(3);

    assign o_redir_v    = i_trap_flag | i_jump_flag;
    assign o_redir_addr = i_trap_flag ? w_trap_addr : (i_jump_addr & w_jump_mask);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: registered PC with req/gnt issue, optional RVC
// stepping and a one-entry pending-redirect buffer for redirects during a stall.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CPU_RESET_ADDR),
    parameter int unsigned       HOLD_W     = HOLD_FLAG_W,
    parameter bit                RVC_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    jtag_reset_flag_i,
    input  logic                    trap_flag_i,
    input  logic                    trap_irq_i,
    input  logic [TRAP_CAUSE_W-1:0] trap_cause_i,
    input  logic [ADDR_W-1:0]       mtvec_i,
    input  logic                    jump_flag_i,
    input  logic [ADDR_W-1:0]       jump_addr_i,
    input  logic [HOLD_W-1:0]       hold_flag_i,
    input  logic                    step_c_i,
    input  logic                    fetch_gnt_i,
    output logic                    fetch_req_o,
    output logic [ADDR_W-1:0]       pc_o,
    output logic [ADDR_W-1:0]       pc_prev_o
);

    pc_state_e         r_state;
    logic              r_fetch_req;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_prev;
    logic              r_pend_v;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_redir_v;
    logic [ADDR_W-1:0] w_redir_addr;
    logic              w_hold;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_pc_seq;

    pc_redirect_mux #(
        .ADDR_W (ADDR_W),
        .RVC_EN (RVC_EN)
    ) u_redirect_mux (
        .i_trap_flag  (trap_flag_i),
        .i_trap_irq   (trap_irq_i),
        .i_trap_cause (trap_cause_i),
        .i_mtvec      (mtvec_i),
        .i_jump_flag  (jump_flag_i),
        .i_jump_addr  (jump_addr_i),
        .o_redir_v    (w_redir_v),
        .o_redir_addr (w_redir_addr)
    );

    assign w_hold   = (hold_flag_i >= HOLD_W'(HOLD_PC));
    assign w_step   = (RVC_EN && step_c_i) ? ADDR_W'(2) : ADDR_W'(4);
    assign w_pc_seq = r_pc + w_step;

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= PC_ST_RST;
            r_fetch_req <= 1'b0;
            r_pc        <= RESET_ADDR;
            r_pc_prev   <= RESET_ADDR;
            r_pend_v    <= 1'b0;
            r_pend_addr <= RESET_ADDR;
        end else if (jtag_reset_flag_i) begin
            r_state     <= PC_ST_RST;
            r_fetch_req <= 1'b0;
            r_pc        <= RESET_ADDR;
            r_pend_v    <= 1'b0;
        end else begin
            unique case (r_state)
                PC_ST_RST: begin
                    if (w_redir_v) r_pc <= w_redir_addr;
                    r_state     <= PC_ST_RUN;
                    r_fetch_req <= 1'b1;
                end
                PC_ST_RUN: begin
                    if (fetch_gnt_i) begin
                        r_pc_prev   <= r_pc;
                        r_pc        <= w_redir_v ? w_redir_addr
                                     : r_pend_v  ? r_pend_addr
                                     : w_pc_seq;
                        r_pend_v    <= 1'b0;
                        r_state     <= w_hold ? PC_ST_HOLD : PC_ST_RUN;
                        r_fetch_req <= ~w_hold;
                    end else if (w_redir_v) begin
                        // Request must stay stable until granted; park the target.
                        r_pend_v    <= 1'b1;
                        r_pend_addr <= w_redir_addr;
                    end
                end
                PC_ST_HOLD: begin
                    if (w_redir_v) r_pc <= w_redir_addr;
                    if (!w_hold) begin
                        r_state     <= PC_ST_RUN;
                        r_fetch_req <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= PC_ST_RST;
                    r_fetch_req <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req_o = r_fetch_req;
    assign pc_o        = r_pc;
    assign pc_prev_o   = r_pc_prev;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: one RVC-enabled and one RVC-disabled instance share stimulus;
// directed scenarios use constant expectations, the random phase uses a model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag, trap, irq, jump, step_c, gnt;
    logic [4:0]  cause;
    logic [31:0] mtvec, jaddr;
    logic [2:0]  hold;

    logic [1:0]        req_w;
    logic [1:0][31:0]  pc_w, prev_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .HOLD_W(3), .RVC_EN(1'b1)) u_dut_rvc (
        .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag), .trap_flag_i(trap), .trap_irq_i(irq),
        .trap_cause_i(cause), .mtvec_i(mtvec), .jump_flag_i(jump), .jump_addr_i(jaddr),
        .hold_flag_i(hold), .step_c_i(step_c), .fetch_gnt_i(gnt),
        .fetch_req_o(req_w[0]), .pc_o(pc_w[0]), .pc_prev_o(prev_w[0]));

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .HOLD_W(3), .RVC_EN(1'b0)) u_dut_norvc (
        .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag), .trap_flag_i(trap), .trap_irq_i(irq),
        .trap_cause_i(cause), .mtvec_i(mtvec), .jump_flag_i(jump), .jump_addr_i(jaddr),
        .hold_flag_i(hold), .step_c_i(step_c), .fetch_gnt_i(gnt),
        .fetch_req_o(req_w[1]), .pc_o(pc_w[1]), .pc_prev_o(prev_w[1]));

    // Reference model: index 0 has compressed stepping, index 1 does not.
    typedef enum {M_RST, M_RUN, M_HOLD} mode_e;
    mode_e       m_mode   [2];
    logic [31:0] m_pc     [2];
    logic [31:0] m_prev   [2];
    logic [31:0] m_pend   [2];
    bit          m_pend_v [2];

    function automatic logic [31:0] model_target(bit rvc);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
        if (trap) return (mtvec[1:0] == 2'b01 && irq) ? base + 32'(cause) * 4 : base;
        return rvc ? (jaddr & ~32'h1) : (jaddr & ~32'h3);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] <= M_RST; m_pc[k] <= 32'h0; m_prev[k] <= 32'h0; m_pend_v[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] tgt;
                bit          redir, held;
                redir = trap || jump;
                held  = (hold != 3'd0);
                tgt   = model_target(k == 0);
                if (jtag) begin
                    m_mode[k] <= M_RST; m_pc[k] <= 32'h0; m_pend_v[k] <= 1'b0;
                end else if (m_mode[k] == M_RUN && gnt) begin
                    m_prev[k]   <= m_pc[k];
                    m_pc[k]     <= redir ? tgt : m_pend_v[k] ? m_pend[k]
                                 : m_pc[k] + ((k == 0 && step_c) ? 32'd2 : 32'd4);
                    m_pend_v[k] <= 1'b0;
                    m_mode[k]   <= held ? M_HOLD : M_RUN;
                end else if (m_mode[k] == M_RUN) begin
                    if (redir) begin m_pend_v[k] <= 1'b1; m_pend[k] <= tgt; end
                end else begin
                    if (redir) m_pc[k] <= tgt;
                    if (m_mode[k] == M_RST || !held) m_mode[k] <= M_RUN;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; jtag = 0; trap = 0; irq = 0; jump = 0; step_c = 0; gnt = 0;
        cause = '0; mtvec = '0; jaddr = '0; hold = '0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || prev_w[k] !== 32'h0 || req_w[k] !== 1'b0)
                $display("FAIL reset dut%0d: pc=%h prev=%h req=%b expected 0/0/0", k, pc_w[k], prev_w[k], req_w[k]);
            else n_pass++;
        end
        rst = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || req_w[k] !== 1'b1)
                $display("FAIL release dut%0d: pc=%h req=%b expected 0/1", k, pc_w[k], req_w[k]);
            else n_pass++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] seq [3] = '{32'h4, 32'h8, 32'hC};
        gnt = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== seq[i] || req_w[k] !== 1'b1)
                    $display("FAIL seq%0d dut%0d: pc=%h req=%b expected %h/1", i, k, pc_w[k], req_w[k], seq[i]);
                else n_pass++;
            end
        end
        jtag = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || req_w[k] !== 1'b0 || prev_w[k] !== 32'h8)
                $display("FAIL jtag_seq dut%0d: pc=%h req=%b prev=%h expected 0/0/8", k, pc_w[k], req_w[k], prev_w[k]);
            else n_pass++;
        end
        jtag = 0;
        tick();
        tick();
        step_c = 1;
        tick();
        n_checks++;
        if (pc_w[0] !== 32'h6) $display("FAIL rvc_step: pc=%h expected 6", pc_w[0]); else n_pass++;
        n_checks++;
        if (pc_w[1] !== 32'h8) $display("FAIL norvc_step: pc=%h expected 8", pc_w[1]); else n_pass++;
        step_c = 0; gnt = 0;
    endtask

    task automatic test_stall_jump();
        logic [31:0] held_pc [2] = '{32'h6, 32'h8};
        jump = 1; jaddr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            jump = 0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== held_pc[k] || req_w[k] !== 1'b1)
                    $display("FAIL stall%0d dut%0d: pc=%h req=%b expected %h/1", i, k, pc_w[k], req_w[k], held_pc[k]);
                else n_pass++;
            end
        end
        gnt = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h100 || prev_w[k] !== held_pc[k])
                $display("FAIL pend_jump dut%0d: pc=%h prev=%h expected 100/%h", k, pc_w[k], prev_w[k], held_pc[k]);
            else n_pass++;
        end
        gnt = 0;
    endtask

    task automatic test_trap_pending();
        logic [31:0] want [3] = '{32'h81C, 32'h800, 32'h800};
        logic [31:0] vec  [3] = '{32'h801, 32'h801, 32'h800};
        bit          irqs [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin jump = 1; jaddr = 32'h180; tick(); jump = 0; end
            trap = 1; irq = irqs[i]; cause = 5'd7; mtvec = vec[i];
            tick();
            trap = 0; gnt = 1;
            tick();
            gnt = 0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== want[i])
                    $display("FAIL trap%0d dut%0d: pc=%h expected %h", i, k, pc_w[k], want[i]);
                else n_pass++;
            end
        end
        jump = 1; jaddr = 32'h200;
        tick();
        jaddr = 32'h300; gnt = 1;
        tick();
        jump = 0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h304 || prev_w[k] !== 32'h300)
                $display("FAIL same_cycle dut%0d: pc=%h prev=%h expected 304/300", k, pc_w[k], prev_w[k]);
            else n_pass++;
        end
        gnt = 0;
    endtask

    task automatic test_hold();
        logic [31:0] e_pc  [5] = '{32'h304, 32'h308, 32'h308, 32'h40, 32'h40};
        logic        e_req [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        hold = 3'd3;
        for (int i = 0; i < 5; i++) begin
            gnt  = (i == 1 || i == 2);
            jump = (i == 3); jaddr = 32'h40;
            if (i == 4) hold = 3'd0;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== e_pc[i] || req_w[k] !== e_req[i])
                    $display("FAIL hold%0d dut%0d: pc=%h req=%b expected %h/%b", i, k, pc_w[k], req_w[k], e_pc[i], e_req[i]);
                else n_pass++;
            end
        end
        gnt = 0; jump = 0;
    endtask

    task automatic test_align_wrap();
        jump = 1; jaddr = 32'h103;
        tick();
        jump = 0; gnt = 1;
        tick();
        gnt = 0;
        n_checks++;
        if (pc_w[0] !== 32'h102) $display("FAIL align_rvc: pc=%h expected 102", pc_w[0]); else n_pass++;
        n_checks++;
        if (pc_w[1] !== 32'h100) $display("FAIL align_norvc: pc=%h expected 100", pc_w[1]); else n_pass++;
        jump = 1; jaddr = 32'hFFFF_FFFC;
        tick();
        jump = 0; gnt = 1;
        tick();
        tick();
        gnt = 0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || prev_w[k] !== 32'hFFFF_FFFC)
                $display("FAIL wrap dut%0d: pc=%h prev=%h expected 0/fffffffc", k, pc_w[k], prev_w[k]);
            else n_pass++;
        end
    endtask

    task automatic test_jtag_and_async();
        jump = 1; jaddr = 32'h500;
        tick();
        jump = 0; jtag = 1;
        tick();
        jtag = 0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || req_w[k] !== 1'b0 || prev_w[k] !== 32'hFFFF_FFFC)
                $display("FAIL jtag dut%0d: pc=%h req=%b prev=%h expected 0/0/fffffffc", k, pc_w[k], req_w[k], prev_w[k]);
            else n_pass++;
        end
        gnt = 1;
        tick();
        tick();
        gnt = 0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h4 || req_w[k] !== 1'b1)
                $display("FAIL jtag_drop_pend dut%0d: pc=%h req=%b expected 4/1", k, pc_w[k], req_w[k]);
            else n_pass++;
        end
        tick();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || prev_w[k] !== 32'h0 || req_w[k] !== 1'b0)
                $display("FAIL async_rst dut%0d: pc=%h prev=%h req=%b expected 0/0/0", k, pc_w[k], prev_w[k], req_w[k]);
            else n_pass++;
        end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 800; i++) begin
            jtag   = ($urandom_range(0, 63) == 0);
            trap   = ($urandom_range(0, 11) == 0);
            irq    = 1'($urandom_range(0, 1));
            cause  = 5'($urandom_range(0, 31));
            r      = $urandom();
            mtvec  = {r[31:2], 1'b0, 1'($urandom_range(0, 1))};
            jump   = ($urandom_range(0, 5) == 0);
            jaddr  = $urandom();
            hold   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            step_c = 1'($urandom_range(0, 1));
            gnt    = ($urandom_range(0, 3) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== m_pc[k] || prev_w[k] !== m_prev[k] || req_w[k] !== (m_mode[k] == M_RUN))
                    $display("FAIL random%0d dut%0d: pc=%h prev=%h req=%b expected %h/%h/%b", i, k,
                             pc_w[k], prev_w[k], req_w[k], m_pc[k], m_prev[k], m_mode[k] == M_RUN);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_jump();
        test_trap_pending();
        test_hold();
        test_align_wrap();
        test_jtag_and_async();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
